// File: rtl/audio_interval_envelope.sv
// Streaming multi-channel interval min/max: accumulates len samples per channel
// over a valid/ready input and emits one signed min/max record per interval.
module audio_interval_envelope #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned IDX_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         interval_len,
    input  logic [IDX_W-1:0]         num_intervals,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_min,
    output logic [NUM_CH*DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]         out_index,
    output logic                     busy,
    output logic                     done
);
    localparam int unsigned BUS_W = NUM_CH * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   nint_q, nint_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BUS_W-1:0]   acc_min_q, acc_min_d;
    logic [BUS_W-1:0]   acc_max_q, acc_max_d;
    logic [BUS_W-1:0]   out_min_q, out_min_d;
    logic [BUS_W-1:0]   out_max_q, out_max_d;
    logic [IDX_W-1:0]   out_index_q, out_index_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BUS_W-1:0]   upd_min, upd_max;

    // Candidate min/max including the current sample; the first sample seeds both.
    always_comb begin
        upd_min = acc_min_q;
        upd_max = acc_max_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cnt_q == '0 ||
                $signed(in_data[c*DATA_W +: DATA_W]) < $signed(acc_min_q[c*DATA_W +: DATA_W]))
                upd_min[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
            if (cnt_q == '0 ||
                $signed(in_data[c*DATA_W +: DATA_W]) > $signed(acc_max_q[c*DATA_W +: DATA_W]))
                upd_max[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        nint_d      = nint_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        acc_min_d   = acc_min_q;
        acc_max_d   = acc_max_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        out_index_d = out_index_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d  = (interval_len == '0) ? LEN_W'(1) : interval_len;
                    nint_d = num_intervals;
                    if (num_intervals == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (in_valid && in_ready_q) begin
                    acc_min_d = upd_min;
                    acc_max_d = upd_max;
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        out_min_d   = upd_min;
                        out_max_d   = upd_max;
                        out_index_d = idx_q;
                        state_d     = S_EMIT;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (idx_q == nint_q - IDX_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = '0;
                        state_d = S_ACCUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake/status flags are registered decodes of the next state.
        in_ready_d  = (state_d == S_ACCUM);
        out_valid_d = (state_d == S_EMIT);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            nint_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            acc_min_q   <= '0;
            acc_max_q   <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_index_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            nint_q      <= nint_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            acc_min_q   <= acc_min_d;
            acc_max_q   <= acc_max_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_index_q <= out_index_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
